// File: rtl/chip8_io_periph_pkg.sv
// Shared bus types and address map for the CHIP-8 CPU and its I/O peripheral.
package chip8_io_periph_pkg;

  typedef enum logic [1:0] {
    DISABLED     = 2'd0,
    READ_ENABLE  = 2'd1,
    WRITE_ENABLE = 2'd2
  } control_unit_state_t;

  localparam logic [15:0] KEYBOARD_ADDR_LO       = 16'h0000;
  localparam logic [15:0] KEYBOARD_ADDR_HI       = 16'h0001;
  localparam logic [15:0] KEYBOARD_WAIT_REL_ADDR = 16'h0002;
  localparam logic [15:0] DELAY_TIMER_ADDR       = 16'h0003;
  localparam logic [15:0] SOUND_TIMER_ADDR       = 16'h0004;
  localparam logic [15:0] RNG_ADDR               = 16'h000B;

  localparam logic [7:0]  KB_NO_KEY = 8'hFF;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Scanning from the top down leaves the lowest set bit as the final answer.
  function automatic logic [3:0] lowestSetIndex(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/chip8_timer60.sv
// 60 Hz divider driving the CHIP-8 delay and sound countdown timers.
module chip8_timer60
  import chip8_io_periph_pkg::*;
#(
  parameter int TIMER_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       delayWe,
  input  logic [7:0] delayWdata,
  input  logic       soundWe,
  input  logic [7:0] soundWdata,
  output logic [7:0] delayT,
  output logic [7:0] soundT,
  output logic       soundOn
);

  localparam int DIV_W = $clog2(TIMER_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TIMER_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       delayT_q, delayT_d;
  logic [7:0]       soundT_q, soundT_d;
  logic             soundOn_q, soundOn_d;
  logic             tick;

  assign tick = (div_q == DIV_LAST);

  // A bus write takes priority over a coincident tick decrement.
  always_comb begin
    div_d     = tick ? '0 : div_q + DIV_W'(1);
    delayT_d  = delayT_q;
    soundT_d  = soundT_q;
    soundOn_d = (soundT_q != 8'd0);
    if (delayWe)                       delayT_d = delayWdata;
    else if (tick && delayT_q != 8'd0) delayT_d = delayT_q - 8'd1;
    if (soundWe)                       soundT_d = soundWdata;
    else if (tick && soundT_q != 8'd0) soundT_d = soundT_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      delayT_q  <= 8'd0;
      soundT_q  <= 8'd0;
      soundOn_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      delayT_q  <= delayT_d;
      soundT_q  <= soundT_d;
      soundOn_q <= soundOn_d;
    end
  end

  assign delayT  = delayT_q;
  assign soundT  = soundT_q;
  assign soundOn = soundOn_q;

endmodule

// File: rtl/chip8_io_periph.sv
// CPU-bus slave for the keypad, delay/sound timers and the LFSR random source.
module chip8_io_periph
  import chip8_io_periph_pkg::*;
#(
  parameter int          TIMER_DIV = 1000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         addr,
  input  control_unit_state_t cu_state,
  input  logic [7:0]          wr_data,
  output logic [7:0]          rd_data,
  output logic                rd_hit,
  input  logic [15:0]         keys,
  output logic                sound_on
);

  logic [15:0] keySync_q, ks_q, ksPrev_q;
  logic        kbArmed_q, kbArmed_d;
  logic        kbValid_q, kbValid_d;
  logic [3:0]  kbKey_q, kbKey_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] rel;
  logic        isWrite, isRead, decoded;
  logic [7:0]  delayT, soundT;

  assign isWrite = (cu_state == WRITE_ENABLE);
  assign isRead  = (cu_state == READ_ENABLE);
  assign rel     = ksPrev_q & ~ks_q;
  assign decoded = (addr == KEYBOARD_ADDR_LO) || (addr == KEYBOARD_ADDR_HI) ||
                   (addr == KEYBOARD_WAIT_REL_ADDR) || (addr == DELAY_TIMER_ADDR) ||
                   (addr == SOUND_TIMER_ADDR) || (addr == RNG_ADDR);

  chip8_timer60 #(.TIMER_DIV(TIMER_DIV)) u_timer60 (
    .clk        (clk),
    .reset      (reset),
    .delayWe    (isWrite && addr == DELAY_TIMER_ADDR),
    .delayWdata (wr_data),
    .soundWe    (isWrite && addr == SOUND_TIMER_ADDR),
    .soundWdata (wr_data),
    .delayT     (delayT),
    .soundT     (soundT),
    .soundOn    (sound_on)
  );

  // Arming clears any previous result and overrides a release seen in the same cycle.
  always_comb begin
    kbArmed_d = kbArmed_q;
    kbValid_d = kbValid_q;
    kbKey_d   = kbKey_q;
    lfsr_d    = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    if (isWrite && addr == KEYBOARD_WAIT_REL_ADDR) begin
      kbArmed_d = 1'b1;
      kbValid_d = 1'b0;
    end else if (kbArmed_q && rel != 16'd0) begin
      kbKey_d   = lowestSetIndex(rel);
      kbValid_d = 1'b1;
      kbArmed_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      keySync_q <= 16'd0;
      ks_q      <= 16'd0;
      ksPrev_q  <= 16'd0;
      kbArmed_q <= 1'b0;
      kbValid_q <= 1'b0;
      kbKey_q   <= 4'd0;
      lfsr_q    <= LFSR_SEED;
    end else begin
      keySync_q <= keys;
      ks_q      <= keySync_q;
      ksPrev_q  <= ks_q;
      kbArmed_q <= kbArmed_d;
      kbValid_q <= kbValid_d;
      kbKey_q   <= kbKey_d;
      lfsr_q    <= lfsr_d;
    end
  end

  always_comb begin
    rd_hit  = isRead && decoded;
    rd_data = 8'h00;
    if (rd_hit) begin
      case (addr)
        KEYBOARD_ADDR_LO:       rd_data = ks_q[7:0];
        KEYBOARD_ADDR_HI:       rd_data = ks_q[15:8];
        KEYBOARD_WAIT_REL_ADDR: rd_data = kbValid_q ? {4'h0, kbKey_q} : KB_NO_KEY;
        DELAY_TIMER_ADDR:       rd_data = delayT;
        SOUND_TIMER_ADDR:       rd_data = soundT;
        RNG_ADDR:               rd_data = lfsr_q[7:0];
        default:                rd_data = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_io_periph.sv
// Directed self-checking bench for chip8_io_periph with a fast timer divider.
module tb_chip8_io_periph;
  import chip8_io_periph_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic [15:0]         addr;
  control_unit_state_t cu_state;
  logic [7:0]          wr_data;
  logic [7:0]          rd_data;
  logic                rd_hit;
  logic [15:0]         keys;
  logic                sound_on;

  int checks = 0;
  int errors = 0;
  int divModel = 0;

  chip8_io_periph #(.TIMER_DIV(4), .LFSR_SEED(16'hACE1)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .cu_state (cu_state),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .rd_hit   (rd_hit),
    .keys     (keys),
    .sound_on (sound_on)
  );

  always #5 clk = ~clk;

  // Expected divider phase, used to place writes relative to timer ticks.
  always @(posedge clk) begin
    if (reset) divModel <= 0;
    else       divModel <= (divModel == 3) ? 0 : divModel + 1;
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input control_unit_state_t cs, input logic [15:0] a,
                               input logic [7:0] d);
    cu_state = cs;
    addr     = a;
    wr_data  = d;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic waitDiv(input int phase);
    for (int i = 0; i < 8 && divModel != phase; i++) step();
  endtask

  initial begin
    reset = 1'b1;
    keys  = 16'h0000;
    applyStimulus(DISABLED, 16'h0000, 8'h00);
    doReset();

    applyStimulus(READ_ENABLE, RNG_ADDR, 8'h00);
    checkOutput("rng0", rd_data, 8'hE1);
    checkOutput("rng0_hit", {7'b0, rd_hit}, 8'h01);
    step();
    checkOutput("rng1", rd_data, 8'h70);
    checkOutput("rng1_hit", {7'b0, rd_hit}, 8'h01);
    step();
    checkOutput("rng2", rd_data, 8'h38);
    checkOutput("rng2_hit", {7'b0, rd_hit}, 8'h01);
    checkOutput("sound_reset", {7'b0, sound_on}, 8'h00);

    applyStimulus(READ_ENABLE, DELAY_TIMER_ADDR, 8'h00);
    checkOutput("delay_reset", rd_data, 8'h00);
    waitDiv(0);
    applyStimulus(WRITE_ENABLE, DELAY_TIMER_ADDR, 8'h02);
    step();
    applyStimulus(READ_ENABLE, DELAY_TIMER_ADDR, 8'h00);
    checkOutput("delay_load", rd_data, 8'h02);
    step(3);
    checkOutput("delay_tick1", rd_data, 8'h01);
    step(4);
    checkOutput("delay_tick2", rd_data, 8'h00);
    step(40);
    checkOutput("delay_hold0", rd_data, 8'h00);
    waitDiv(3);
    applyStimulus(WRITE_ENABLE, DELAY_TIMER_ADDR, 8'h05);
    step();
    applyStimulus(READ_ENABLE, DELAY_TIMER_ADDR, 8'h00);
    checkOutput("delay_write_on_tick", rd_data, 8'h05);
    step(3);
    checkOutput("delay_pre_tick", rd_data, 8'h05);
    step();
    checkOutput("delay_after_tick", rd_data, 8'h04);

    waitDiv(0);
    applyStimulus(WRITE_ENABLE, SOUND_TIMER_ADDR, 8'h01);
    step();
    applyStimulus(READ_ENABLE, SOUND_TIMER_ADDR, 8'h00);
    checkOutput("sound_load", rd_data, 8'h01);
    checkOutput("sound_on_lag", {7'b0, sound_on}, 8'h00);
    step();
    checkOutput("sound_on_rise", {7'b0, sound_on}, 8'h01);
    step(2);
    checkOutput("sound_zero", rd_data, 8'h00);
    checkOutput("sound_on_hold", {7'b0, sound_on}, 8'h01);
    step();
    checkOutput("sound_on_fall", {7'b0, sound_on}, 8'h00);

    applyStimulus(DISABLED, 16'h0000, 8'h00);
    keys = 16'h0028;
    step(3);
    applyStimulus(WRITE_ENABLE, KEYBOARD_WAIT_REL_ADDR, 8'h00);
    step();
    applyStimulus(READ_ENABLE, KEYBOARD_WAIT_REL_ADDR, 8'h00);
    checkOutput("kb_armed", rd_data, 8'hFF);
    keys = 16'h0000;
    step(2);
    checkOutput("kb_pending", rd_data, 8'hFF);
    step();
    checkOutput("kb_release", rd_data, 8'h03);
    step(5);
    checkOutput("kb_hold", rd_data, 8'h03);
    applyStimulus(WRITE_ENABLE, KEYBOARD_WAIT_REL_ADDR, 8'h00);
    step();
    applyStimulus(READ_ENABLE, KEYBOARD_WAIT_REL_ADDR, 8'h00);
    checkOutput("kb_rearm", rd_data, 8'hFF);

    applyStimulus(DISABLED, 16'h0000, 8'h00);
    doReset();
    keys = 16'h0020;
    step(3);
    keys = 16'h0000;
    step(4);
    applyStimulus(READ_ENABLE, KEYBOARD_WAIT_REL_ADDR, 8'h00);
    checkOutput("kb_unarmed_release", rd_data, 8'hFF);
    applyStimulus(WRITE_ENABLE, KEYBOARD_WAIT_REL_ADDR, 8'h00);
    step();
    applyStimulus(READ_ENABLE, KEYBOARD_WAIT_REL_ADDR, 8'h00);
    checkOutput("kb_arm_after_unarmed", rd_data, 8'hFF);
    keys = 16'h0020;
    step(3);
    doReset();
    step(3);
    keys = 16'h0000;
    step(4);
    checkOutput("kb_reset_disarms", rd_data, 8'hFF);

    keys = 16'h8001;
    step();
    applyStimulus(READ_ENABLE, KEYBOARD_ADDR_LO, 8'h00);
    checkOutput("keys_lo_latency", rd_data, 8'h00);
    step();
    checkOutput("keys_lo", rd_data, 8'h01);
    applyStimulus(READ_ENABLE, KEYBOARD_ADDR_HI, 8'h00);
    checkOutput("keys_hi", rd_data, 8'h80);
    checkOutput("keys_hi_hit", {7'b0, rd_hit}, 8'h01);
    applyStimulus(READ_ENABLE, 16'h0006, 8'h00);
    checkOutput("ppu_hit", {7'b0, rd_hit}, 8'h00);
    checkOutput("ppu_data", rd_data, 8'h00);
    applyStimulus(DISABLED, KEYBOARD_ADDR_LO, 8'h00);
    checkOutput("disabled_hit", {7'b0, rd_hit}, 8'h00);
    checkOutput("disabled_data", rd_data, 8'h00);
    applyStimulus(WRITE_ENABLE, KEYBOARD_ADDR_LO, 8'h55);
    step();
    applyStimulus(READ_ENABLE, KEYBOARD_ADDR_LO, 8'h00);
    checkOutput("keys_write_ignored", rd_data, 8'h01);
    applyStimulus(READ_ENABLE, DELAY_TIMER_ADDR, 8'h00);
    checkOutput("keys_write_no_delay", rd_data, 8'h00);
    applyStimulus(READ_ENABLE, KEYBOARD_WAIT_REL_ADDR, 8'h00);
    checkOutput("keys_write_no_kb", rd_data, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
